// File: rtl/fourth_phase_d.sv
// Radix-2 restoring significand divider: Q = floor(X*2^(W_Sgf+1)/Y) plus sticky.
// Latency W_Sgf+2 iterations after the load edge; start is ignored while busy (no queueing).
module fourth_phase_d #(
    parameter int W_Sgf = 53
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [W_Sgf:0]   Sgf_X,
    input  logic [W_Sgf:0]   Sgf_Y,
    output logic [W_Sgf+1:0] Q_Sgf,
    output logic             sticky,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic             ovf
);

    localparam int RW = W_Sgf + 2;
    localparam int CW = $clog2(W_Sgf + 2);
    localparam logic [CW-1:0] CNT_INIT = CW'(W_Sgf + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [W_Sgf:0]  y_q, y_d;
    logic [RW-1:0]   r_q, r_d;
    logic [RW-1:0]   quo_q, quo_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [RW-1:0]   q_sgf_q, q_sgf_d;
    logic            sticky_q, sticky_d;
    logic            div_zero_q, div_zero_d;
    logic            ovf_q, ovf_d;

    logic [RW-1:0]   y_ext;
    logic [RW-1:0]   diff;
    logic            q_bit;

    always_comb begin
        state_d    = state_q;
        y_d        = y_q;
        r_d        = r_q;
        quo_d      = quo_q;
        cnt_d      = cnt_q;
        q_sgf_d    = q_sgf_q;
        sticky_d   = sticky_q;
        div_zero_d = div_zero_q;
        ovf_d      = ovf_q;

        y_ext = {1'b0, y_q};
        q_bit = (r_q >= y_ext);
        diff  = q_bit ? (r_q - y_ext) : r_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    y_d        = Sgf_Y;
                    div_zero_d = 1'b0;
                    ovf_d      = 1'b0;
                    sticky_d   = 1'b0;
                    if (Sgf_Y == '0) begin
                        q_sgf_d    = '1;
                        div_zero_d = 1'b1;
                        state_d    = DONE;
                    end else if ({1'b0, Sgf_X} >= {Sgf_Y, 1'b0}) begin
                        q_sgf_d = '1;
                        ovf_d   = 1'b1;
                        state_d = DONE;
                    end else begin
                        // The dividend lives in the partial remainder from here on.
                        r_d     = {1'b0, Sgf_X};
                        quo_d   = '0;
                        cnt_d   = CNT_INIT;
                        state_d = ITER;
                    end
                end
            end
            ITER: begin
                // diff < Y here, so dropping its MSB on the shift loses nothing.
                r_d   = {diff[RW-2:0], 1'b0};
                quo_d = {quo_q[RW-2:0], q_bit};
                if (cnt_q == '0) begin
                    q_sgf_d  = {quo_q[RW-2:0], q_bit};
                    sticky_d = |diff;
                    state_d  = DONE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            y_q        <= '0;
            r_q        <= '0;
            quo_q      <= '0;
            cnt_q      <= '0;
            q_sgf_q    <= '0;
            sticky_q   <= 1'b0;
            div_zero_q <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            y_q        <= y_d;
            r_q        <= r_d;
            quo_q      <= quo_d;
            cnt_q      <= cnt_d;
            q_sgf_q    <= q_sgf_d;
            sticky_q   <= sticky_d;
            div_zero_q <= div_zero_d;
            ovf_q      <= ovf_d;
        end
    end

    assign Q_Sgf    = q_sgf_q;
    assign sticky   = sticky_q;
    assign div_zero = div_zero_q;
    assign ovf      = ovf_q;
    assign busy     = (state_q != IDLE);
    assign done     = (state_q == DONE);

endmodule

// File: doc/fourth_phase_d.md
# fourth_phase_d

Sequential significand divider for the floating-point unit's division path. It mirrors the significand multiply stage: it registers both significands on a start strobe, then runs radix-2 restoring division over W_Sgf+2 cycles. It returns a quotient with one integer bit, W_Sgf+1 fraction bits and a sticky bit for the downstream normalize/round stage. Operands are normalized significands (1.f, MSB set), so the quotient lies in (0.5, 2).

## Interface
- W_Sgf, default 53 (double precision; 24 for single): significand width parameter.
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  operand-load strobe; accepted only in IDLE.
- Sgf_X  in  W_Sgf+1  dividend significand (unsigned).
- Sgf_Y  in  W_Sgf+1  divisor significand (unsigned).
- Q_Sgf  out  W_Sgf+2  quotient, floor(X·2^(W_Sgf+1)/Y).
- sticky  out  1  final remainder ≠ 0.
- busy  out  1  high while not IDLE.
- done  out  1  one-cycle completion pulse.
- div_zero  out  1  Y was 0 at accepted start.
- ovf  out  1  X ≥ 2·Y at accepted start; quotient out of range.

## Operation
- FSM states:
  - IDLE: on start=1, latch X and Y into internal registers, clear div_zero, ovf and sticky, then branch:
    - Y==0: Q_Sgf ← all ones, div_zero←1, go to DONE.
    - else X ≥ 2Y: Q_Sgf ← all ones, ovf←1, go to DONE.
    - else R←X (W_Sgf+2 bits), cnt←W_Sgf+1, go to ITER.
  - ITER: each cycle, bit q = (R ≥ Y).
    - R_next = (R − q·Y) << 1.
    - Shift q into the internal quotient register, MSB first.
    - At cnt==0: load Q_Sgf from the quotient register plus the final q, set sticky = ((R − q·Y) ≠ 0), go to DONE.
    - Otherwise cnt decrements.
  - DONE: done=1 for exactly this cycle; unconditionally go to IDLE.
- Width rules:
  - R < Y holds before each shift, so R fits in W_Sgf+2 bits with no overflow.
  - The comparison and subtraction are W_Sgf+2 bits wide, with Y zero-extended.
- Q_Sgf, sticky, div_zero and ovf change only when DONE is entered; they hold until the next DONE. div_zero, ovf and sticky also clear at an accepted start. Intermediate quotient bits are never visible on Q_Sgf.
- start in ITER or DONE is ignored: operand registers are untouched and there is no queueing.
- Sgf_X and Sgf_Y may change freely after the accepting edge.

## Timing
- Reset values: state=IDLE; Q_Sgf=0, sticky=0, busy=0, done=0, div_zero=0, ovf=0; internal R, quotient and cnt all 0.
- Reset asserted mid-division aborts immediately; there is no done pulse.
- Normal latency: with start accepted at edge k, the ITER edges are k+1 … k+W_Sgf+2. done is high during the cycle after edge k+W_Sgf+2, which is 55 edges for W_Sgf=53. busy is high from after edge k until DONE exits.
- Exception latency (div_zero/ovf): done is high during the cycle after edge k. busy is high only in that same cycle.
- Minimum start-to-start spacing: W_Sgf+4 cycles normal, 2 cycles on exceptions.
- done is a strict single-cycle pulse and is never high in two consecutive cycles.

## Test plan
All scenarios use W_Sgf=53.
- X=Y=2^53 (1.0/1.0): Q_Sgf=2^54 (0x40000000000000), sticky=0, done 55 edges after start, div_zero=ovf=0.
- X=3·2^52 (1.5), Y=2^53 (1.0): Q_Sgf=3·2^53 (0x60000000000000), sticky=0.
- X=2^53 (1.0), Y=3·2^52 (1.5): Q_Sgf=0x2AAAAAAAAAAAAA, sticky=1.
- Y=0, X=2^53: done on the cycle after the start edge, div_zero=1, Q_Sgf=all ones (2^55−1), busy high one cycle. Then X=2^54−1, Y=1: ovf=1, div_zero=0, Q_Sgf=all ones.
- Start 1.0/1.0; pulse start at edges k+10 and k+55 with other operands. Both are ignored: result stays 0x40000000000000 with one done pulse. Then toggle Sgf_X/Sgf_Y mid-run: the result is unchanged.
- Assert rst at edge k+20 of a running division: all outputs go 0 asynchronously, no done pulse. After release, a new 1.5/1.0 division completes correctly in 55 edges.
